bitstream_scan_ctrl: RTL and testbench
======================================

# bitstream_scan_ctrl

Word-level front end and sequencer for the overlapping serial "1011" Moore detector. The block accepts parallel words over a valid/ready handshake and shifts them MSB-first into a bit-enabled detector core, one bit per clock. It counts detector hits into a saturating counter and raises a sticky threshold flag. It sits between the word producer and the status/interrupt logic.

## Interface
- DATA_W, default 8: input word width; bits per word scanned.
- CNT_W, default 16: match counter and threshold width.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  scan enable; gates word acceptance only.
- clr  in  1  synchronous clear of detector, counter, flags and in-flight word.
- s_data  in  DATA_W  input word.
- s_valid  in  1  producer has a word.
- s_ready  out  1  block can take a word this cycle.
- thresh  in  CNT_W  match threshold; 0 disables thresh_hit.
- busy  out  1  word being shifted (FSM in SHIFT).
- match_pulse  out  1  one-cycle strobe per detected pattern.
- match_cnt  out  CNT_W  saturating count of matches.
- thresh_hit  out  1  sticky: match_cnt reached thresh.

## Operation
- Controller FSM: IDLE, SHIFT. Registers: sreg[DATA_W], bit_idx (clog2 DATA_W bits).
- s_ready = en & !clr & (IDLE | (SHIFT & bit_idx == DATA_W-1)).
- Accept = s_valid & s_ready: load sreg <= s_data, bit_idx <= 0, go/stay SHIFT.
- SHIFT, each cycle: core bit = sreg[DATA_W-1], bit_en = 1; sreg shifts left; bit_idx increments. On last bit with no accept: go IDLE.
- en low mid-word: current word completes; no new accept.
- Core (Moore, states S0..S4, S4 = "1011" seen): with bit_en, S0:1→S1,0→S0; S1:1→S1,0→S2; S2:1→S3,0→S0; S3:1→S4,0→S2; S4:1→S1,0→S2. Without bit_en the state holds. Overlap is allowed.
- Core state persists across words, idle gaps and en toggles. Only clr and rst return it to S0.
- hit = bit_en & state==S3 & bit. This is the transition into S4 and fires once per match, even if the core stalls in S4.
- On the edge where hit=1: match_pulse <= 1 (else 0); match_cnt <= match_cnt+1, saturating at all-ones.
- thresh_hit is set when thresh != 0 and the updated match_cnt >= thresh. It holds until clr or rst. A thresh change does not clear it.
- clr wins over everything: core → S0, match_cnt, match_pulse, thresh_hit → 0, FSM → IDLE, the in-flight word is discarded, and no accept occurs that cycle.

## Timing
- Reset values: s_ready=0 during rst (then en-dependent), busy=0, match_pulse=0, match_cnt=0, thresh_hit=0, core S0, FSM IDLE.
- Accept at edge T0 → bit k consumed at edge T(k+1); last bit at T(DATA_W).
- Match latency: the edge consuming the 4th pattern bit sets match_pulse and match_cnt together. Both are visible in the following cycle. thresh_hit is set one edge later, from the registered count.
- Throughput: one word per DATA_W cycles with s_valid held; no bubble between words.
- Asynchronous rst mid-SHIFT: immediate return to reset values; the word is lost.

## Structure
- Package bitscan_pkg: core state encoding (S0..S4, 3-bit) and controller FSM state enum.
- Sub-module detect_1011_core (clk, rst, clr, bit_en, bit, hit, state). The controller holds the shift, handshake, counter and flag logic.

## Test plan
- rst, en=1, thresh=0, word 8'hB0 → one match_pulse, in the cycle after the 4th bit edge; match_cnt=1; thresh_hit=0.
- Words 8'hB6 then 8'hC0, back-to-back → 3 pulses (bits 3, 6, 9 of the stream; one crosses the word boundary); match_cnt=3.
- s_valid held, 4 words of 8'hBB, DATA_W=8 → 4 accepts exactly 8 cycles apart, busy continuously high, match_cnt=8.
- thresh=3, repeat the 8'hBB stream → thresh_hit rises one cycle after match_cnt becomes 3 and stays high; set thresh=100 → stays high; clr → 0.
- CNT_W=4, 10 words of 8'hBB → match_cnt saturates at 15; further pulses still occur; no wrap to 0.
- Word 8'h05 (core ends in S3), then clr, then 8'h80 → no match, match_cnt=0. Without clr the same stream gives match_cnt=1. Also: rst asserted at bit_idx=3 → all outputs at reset values immediately.

Source files
------------

// File: rtl/bitscan_pkg.sv
// Shared encodings for the "1011" bitstream scanner: detector core states
// and the word controller FSM states.
package bitscan_pkg;

  // Detector core: S4 means "1011" has just been seen.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } core_state_t;

  // Word controller: idle waiting for a word, or shifting one out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/detect_1011_core.sv
// Overlapping Moore detector for the serial pattern "1011".
// Advances only on bit_en; state persists until clr or rst.
// hit marks the transition into S4, so it fires once per match.
module detect_1011_core
  import bitscan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic       hit,
  output logic [2:0] state
);

  core_state_t state_q, state_d;

  // State register; async reset to S0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S0;
    else     state_q <= state_d;
  end

  // Next-state and hit decode; clr overrides any bit.
  always_comb begin
    state_d = state_q;
    hit     = bit_en & (state_q == S3) & bit_in;
    if (clr) begin
      state_d = S0;
    end else if (bit_en) begin
      case (state_q)
        S0:      state_d = bit_in ? S1 : S0;
        S1:      state_d = bit_in ? S1 : S2;
        S2:      state_d = bit_in ? S3 : S0;
        S3:      state_d = bit_in ? S4 : S2;
        S4:      state_d = bit_in ? S1 : S2;
        default: state_d = S0;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: rtl/bitstream_scan_ctrl.sv
// Word front end for the "1011" detector: accepts words over valid/ready,
// shifts them MSB-first into the core one bit per clock, counts matches
// into a saturating counter and raises a sticky threshold flag.
//
// Handshake: a word transfers on a rising edge where s_valid and s_ready
// are both high. s_ready is combinational and only depends on en, clr, rst
// and controller state, never on s_valid. The producer holds s_data stable
// while s_valid is high and not yet accepted.
module bitstream_scan_ctrl
  import bitscan_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CNT_W-1:0]  thresh,
  output logic              busy,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              thresh_hit
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  ctrl_state_t       state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              last_bit, accept, bit_en, hit;
  logic [2:0]        core_state;

  // A new word may land on the same edge the last bit of the current one
  // is consumed, which gives back-to-back words with no bubble.
  assign last_bit = (state_q == SHIFT) && (idx_q == LAST_IDX);
  assign s_ready  = en & ~clr & ~rst & ((state_q == IDLE) | last_bit);
  assign accept   = s_valid & s_ready;
  assign bit_en   = (state_q == SHIFT) & ~clr;
  assign busy     = (state_q == SHIFT);

  detect_1011_core u_core (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .bit_en (bit_en),
    .bit_in (sreg_q[DATA_W-1]),
    .hit    (hit),
    .state  (core_state)
  );

  // Controller state, shift register and bit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
    end
  end

  // Controller next state: clr discards the word, accept loads, else shift.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    if (clr) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = SHIFT;
      sreg_d  = s_data;
      idx_d   = '0;
    end else if (state_q == SHIFT) begin
      sreg_d = sreg_q << 1;
      idx_d  = idx_q + IDX_W'(1);
      if (last_bit) state_d = IDLE;
    end
  end

  // Match strobe and saturating match counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_pulse <= 1'b0;
      match_cnt   <= '0;
    end else if (clr) begin
      match_pulse <= 1'b0;
      match_cnt   <= '0;
    end else begin
      match_pulse <= hit;
      if (hit && (match_cnt != CNT_MAX)) match_cnt <= match_cnt + CNT_W'(1);
    end
  end

  // Sticky threshold flag, evaluated from the registered count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thresh_hit <= 1'b0;
    end else if (clr) begin
      thresh_hit <= 1'b0;
    end else if ((thresh != '0) && (match_cnt >= thresh)) begin
      thresh_hit <= 1'b1;
    end
  end

  // The core can only ever sit in one of its five encoded states.
  core_state_legal: assert property (@(posedge clk) disable iff (rst) core_state <= 3'd4);

endmodule

// File: tb/tb_bitstream_scan_ctrl.sv
// Bench for bitstream_scan_ctrl: directed scenarios plus random words,
// with a pattern-search reference model feeding an expected-match queue
// that a monitor drains on every match_pulse. A second instance with a
// 4-bit counter shares the stimulus to exercise saturation.
module tb_bitstream_scan_ctrl;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst, en, clr, s_valid;
  logic [DATA_W-1:0] s_data;
  logic [CNT_W-1:0]  thresh;
  logic              s_ready, busy, match_pulse, thresh_hit;
  logic [CNT_W-1:0]  match_cnt;
  logic              s_ready4, busy4, match_pulse4, thresh_hit4;
  logic [3:0]        match_cnt4;

  bitstream_scan_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .thresh(thresh), .busy(busy), .match_pulse(match_pulse),
    .match_cnt(match_cnt), .thresh_hit(thresh_hit)
  );

  bitstream_scan_ctrl #(.DATA_W(DATA_W), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready4), .thresh(thresh[3:0]), .busy(busy4), .match_pulse(match_pulse4),
    .match_cnt(match_cnt4), .thresh_hit(thresh_hit4)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [CNT_W-1:0] exp_q[$];
  logic [3:0]       exp4_q[$];
  int               exp_cyc_q[$];
  int               acc_cyc[$];

  // Reference model: last four stream bits, match total, sticky flags.
  logic [3:0] hist;
  int         nbits, m_cnt, hit_cyc;
  bit         sticky, sticky4, busy_watch;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_clear();
    hist    = 4'b0000;
    nbits   = 0;
    m_cnt   = 0;
    sticky  = 1'b0;
    sticky4 = 1'b0;
    hit_cyc = -10;
    exp_q.delete();
    exp4_q.delete();
    exp_cyc_q.delete();
  endtask

  // Word accepted at edge t0: bit k is consumed at edge t0+k+1 and a match
  // on that bit is visible in the cycle that follows that edge.
  task automatic model_word(input logic [DATA_W-1:0] w, input int t0);
    for (int k = 0; k < DATA_W; k++) begin
      hist = {hist[2:0], w[DATA_W-1-k]};
      nbits++;
      if (nbits >= 4 && hist == 4'b1011) begin
        m_cnt++;
        exp_q.push_back(CNT_W'(sat(m_cnt, 65535)));
        exp4_q.push_back(4'(sat(m_cnt, 15)));
        exp_cyc_q.push_back(t0 + k + 1);
        if (!sticky && thresh != 0 && m_cnt >= int'(thresh)) begin
          sticky  = 1'b1;
          hit_cyc = t0 + k + 1;
        end
        if (thresh[3:0] != 0 && sat(m_cnt, 15) >= int'(thresh[3:0])) sticky4 = 1'b1;
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic [CNT_W-1:0] mon_e;
  logic [3:0]       mon_e4;
  int               mon_c;

  always @(negedge clk) begin
    if (!rst) begin
      if (match_pulse || match_pulse4) begin
        if (exp_q.size() == 0) begin
          check("spurious_pulse", 32'd1, 32'd0);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_e4 = exp4_q.pop_front();
          mon_c  = exp_cyc_q.pop_front();
          check("pulse_cycle", cyc, mon_c);
          check("pulse16", match_pulse, 1);
          check("pulse4", match_pulse4, 1);
          check("match_cnt", match_cnt, mon_e);
          check("match_cnt4", match_cnt4, mon_e4);
        end
      end
      if (cyc == hit_cyc)     check("thresh_hit_early", thresh_hit, 0);
      if (cyc == hit_cyc + 1) check("thresh_hit_rise", thresh_hit, 1);
      if (busy_watch)         check("busy_held", busy, 1);
    end
  end

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic send_word(input logic [DATA_W-1:0] w, input bit hold_after);
    int guard;
    guard   = 0;
    s_data  = w;
    s_valid = 1'b1;
    #1;
    while (!s_ready) begin
      @(negedge clk);
      #1;
      guard++;
      if (guard > 100) begin
        check("accept_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        return;
      end
    end
    model_word(w, cyc + 1);
    acc_cyc.push_back(cyc + 1);
    @(negedge clk);
    if (!hold_after) s_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy || busy4) begin
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        check("drain_timeout", 32'd0, 32'd1);
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_qlen"}, exp_q.size(), 0);
    check({tag, "_cnt"}, match_cnt, m_cnt);
    check({tag, "_cnt4"}, match_cnt4, sat(m_cnt, 15));
    check({tag, "_thr"}, thresh_hit, sticky);
    check({tag, "_thr4"}, thresh_hit4, sticky4);
    check({tag, "_busy"}, busy, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    check("watchdog", 32'd0, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    rst = 1'b1; en = 1'b1; clr = 1'b0; s_valid = 1'b0; s_data = '0; thresh = '0;
    busy_watch = 1'b0;
    model_clear();

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_pulse", match_pulse, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_thr", thresh_hit, 0);
    rst = 1'b0;
    #1;
    check("idle_s_ready", s_ready, 1);
    @(negedge clk);

    // Single word B0: one match on bit 3.
    send_word(8'hB0, 1'b0);
    drain();
    check("b0_cnt", match_cnt, 1);
    check_quiet("b0");

    // B6 then C0 back-to-back: three matches, one across the boundary.
    do_clr();
    send_word(8'hB6, 1'b1);
    send_word(8'hC0, 1'b0);
    drain();
    check("b6c0_cnt", match_cnt, 3);
    check_quiet("b6c0");

    // Four BB words with s_valid held: full throughput, busy never drops.
    do_clr();
    acc_cyc.delete();
    send_word(8'hBB, 1'b1);
    busy_watch = 1'b1;
    for (int i = 0; i < 3; i++) send_word(8'hBB, i < 2);
    repeat (6) @(negedge clk);
    busy_watch = 1'b0;
    for (int i = 0; i < 3; i++) check("accept_spacing", acc_cyc[i+1] - acc_cyc[i], 8);
    drain();
    check("bb4_cnt", match_cnt, 8);
    check_quiet("bb4");

    // Threshold 3: flag rises one cycle after the count reaches 3, sticks.
    thresh = 16'd3;
    do_clr();
    for (int i = 0; i < 4; i++) send_word(8'hBB, i < 3);
    drain();
    check_quiet("thr3");
    thresh = 16'd100;
    repeat (3) @(negedge clk);
    check("thr_sticky", thresh_hit, 1);
    do_clr();
    #1;
    check("thr_clr", thresh_hit, 0);
    @(negedge clk);

    // Ten BB words: 4-bit counter pins at 15, pulses keep coming.
    thresh = 16'd0;
    do_clr();
    for (int i = 0; i < 10; i++) send_word(8'hBB, i < 9);
    drain();
    check("sat_cnt4", match_cnt4, 15);
    check("sat_cnt16", match_cnt, 20);
    check_quiet("sat");

    // 05 leaves the core in S3; clr wipes it, so 80 does not match.
    do_clr();
    send_word(8'h05, 1'b0);
    drain();
    do_clr();
    send_word(8'h80, 1'b0);
    drain();
    check("clr_nomatch", match_cnt, 0);
    check_quiet("clr_nomatch");

    // Same stream without clr: the state carries over and gives one match.
    do_clr();
    send_word(8'h05, 1'b0);
    repeat (5) @(negedge clk);
    send_word(8'h80, 1'b0);
    drain();
    check("carry_match", match_cnt, 1);
    check_quiet("carry");

    // Async reset with bit_idx at 3: outputs return at once, word lost.
    send_word(8'hB0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_busy4", busy4, 0);
    check("mid_rst_ready", s_ready, 0);
    check("mid_rst_pulse", match_pulse, 0);
    check("mid_rst_cnt", match_cnt, 0);
    check("mid_rst_thr", thresh_hit, 0);
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drain();
    check_quiet("post_rst");

    // Random words with gaps, held valid and en toggles mid-word.
    thresh = 16'($urandom_range(1, 30));
    do_clr();
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 3);
      send_word(8'($urandom), r == 0);
      if (r == 1) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end else if (r == 2) begin
        en = 1'b0;
        repeat ($urandom_range(1, 10)) @(negedge clk);
        en = 1'b1;
      end
    end
    s_valid = 1'b0;
    drain();
    check_quiet("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
